// File: rtl/timer_pkg.sv
// Shared definitions for the timer front-panel entry stage: FSM state
// encodings, time field width, default preset limit and the wrap helper.
package timer_pkg;

  localparam int TIME_W          = 6;
  localparam int MAX_VAL_DEFAULT = 59;

  typedef enum logic [1:0] {
    EDIT = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Increment a minutes/seconds field, rolling over to zero after max_v.
  function automatic logic [TIME_W-1:0] wrap_inc(
    input logic [TIME_W-1:0] v,
    input logic [TIME_W-1:0] max_v
  );
    logic [TIME_W-1:0] r;
    if (v == max_v) r = '0;
    else            r = v + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/timer_preset_entry_btn_debounce.sv
// Single push-button conditioning path: 2-flop synchronizer, stability
// counter that accepts a level after DEBOUNCE_CYCLES identical samples, and
// a registered rising-edge detector producing a one-cycle press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Count consecutive samples that disagree with the accepted level; any
  // sample that agrees again restarts the run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      btn_level <= 1'b0;
    end else if (sync_q2 == btn_level) begin
      cnt <= '0;
    end else if (cnt == CNT_END) begin
      cnt       <= '0;
      btn_level <= sync_q2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_d   <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      level_d   <= btn_level;
      btn_press <= btn_level & ~level_d;
    end
  end

endmodule

// File: rtl/timer_preset_entry.sv
// Front-panel preset entry for the countdown timer: debounced buttons, min/sec
// preset editing, load pulse and run/done status. Optional auto-repeat of the
// min/sec buttons is enabled with `define TIMER_PRESET_AUTO_REPEAT_EN.
module timer_preset_entry
  import timer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int MAX_VAL         = MAX_VAL_DEFAULT,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_min,
  input  logic              btn_sec,
  input  logic              btn_clr,
  input  logic              btn_start,
  input  logic              timer_done,
  output logic [TIME_W-1:0] min,
  output logic [TIME_W-1:0] sec,
  output logic              load,
  output logic              running,
  output logic              expired
);

  localparam logic [TIME_W-1:0] MAX_V = TIME_W'(MAX_VAL);

  logic press_min, press_sec, press_clr, press_start;
  logic level_min, level_sec, level_clr, level_start;
  logic inc_min, inc_sec;
  logic unused_levels;

  state_t            state, state_nxt;
  logic [TIME_W-1:0] min_nxt, sec_nxt;
  logic              load_c;
  logic              first_run;
  logic              any_press;
  logic              preset_zero;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_min (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_min),
    .btn_level(level_min), .btn_press(press_min)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sec (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_sec),
    .btn_level(level_sec), .btn_press(press_sec)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clr (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_clr),
    .btn_level(level_clr), .btn_press(press_clr)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_start),
    .btn_level(level_start), .btn_press(press_start)
  );

`ifdef TIMER_PRESET_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RPT_W   = $clog2(RPT_MAX);
  localparam logic [RPT_W-1:0] DELAY_END = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RATE_END  = RPT_W'(REPEAT_RATE - 1);

  logic [1:0] rpt_level;
  logic [1:0] rpt_hit;

  assign rpt_level = {level_sec, level_min};

  // Hold counter per edit button: first repeat after REPEAT_DELAY, then one
  // every REPEAT_RATE cycles; restarts on release or when leaving EDIT.
  for (genvar g = 0; g < 2; g++) begin : g_rpt
    logic [RPT_W-1:0] cnt;
    logic             armed;

    assign rpt_hit[g] = rpt_level[g] && (state == EDIT) &&
                        (cnt == (armed ? RATE_END : DELAY_END));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt   <= '0;
        armed <= 1'b0;
      end else if (!rpt_level[g] || (state != EDIT)) begin
        cnt   <= '0;
        armed <= 1'b0;
      end else if (rpt_hit[g]) begin
        cnt   <= '0;
        armed <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign inc_min       = press_min | rpt_hit[0];
  assign inc_sec       = press_sec | rpt_hit[1];
  assign unused_levels = level_clr ^ level_start;
`else
  localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_RATE;

  assign inc_min       = press_min;
  assign inc_sec       = press_sec;
  assign unused_levels = level_min ^ level_sec ^ level_clr ^ level_start;
`endif

  assign any_press   = press_min | press_sec | press_clr | press_start;
  assign preset_zero = (min == '0) && (sec == '0);
  assign load        = load_c;

  // Next-state and preset update. Clear dominates everything, a valid start
  // freezes the preset, and increments only apply when no start is taken.
  always_comb begin
    state_nxt = state;
    min_nxt   = min;
    sec_nxt   = sec;
    load_c    = 1'b0;
    case (state)
      EDIT: begin
        if (press_clr) begin
          min_nxt = '0;
          sec_nxt = '0;
        end else if (press_start && !preset_zero) begin
          load_c    = 1'b1;
          state_nxt = RUN;
        end else begin
          if (inc_min) min_nxt = wrap_inc(min, MAX_V);
          if (inc_sec) sec_nxt = wrap_inc(sec, MAX_V);
        end
      end
      RUN: begin
        if (press_clr)                     state_nxt = EDIT;
        else if (timer_done && !first_run) state_nxt = DONE;
      end
      DONE: begin
        if (press_clr) begin
          state_nxt = EDIT;
          min_nxt   = '0;
          sec_nxt   = '0;
        end else if (any_press) begin
          state_nxt = EDIT;
        end
      end
      default: state_nxt = EDIT;
    endcase
  end

  // first_run masks a done flag left over from the previous countdown during
  // the cycle right after load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EDIT;
      min       <= '0;
      sec       <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
      first_run <= 1'b0;
    end else begin
      state     <= state_nxt;
      min       <= min_nxt;
      sec       <= sec_nxt;
      running   <= (state_nxt == RUN);
      expired   <= (state_nxt == DONE);
      first_run <= load_c;
    end
  end

endmodule

// File: tb/tb_timer_preset_entry.sv
// Self-checking bench for timer_preset_entry: directed vector table, hand
// sequences for glitch/stale-done/reset corners, and randomized presses.
module tb_timer_preset_entry;

  localparam int DB    = 4;
  localparam int HOLD  = DB + 6;
  localparam int GAP   = DB + 8;
  localparam int MAXV  = 59;
  localparam int S_EDIT = 0, S_RUN = 1, S_DONE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_min = 1'b0, btn_sec = 1'b0, btn_clr = 1'b0, btn_start = 1'b0;
  logic       timer_done = 1'b0;
  logic [5:0] min, sec;
  logic       load, running, expired;

  always #5 clk = ~clk;

  timer_preset_entry #(
    .DEBOUNCE_CYCLES(DB), .MAX_VAL(MAXV), .REPEAT_DELAY(20), .REPEAT_RATE(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_min(btn_min), .btn_sec(btn_sec), .btn_clr(btn_clr), .btn_start(btn_start),
    .timer_done(timer_done),
    .min(min), .sec(sec), .load(load), .running(running), .expired(expired)
  );

  typedef struct {
    logic [3:0] btns;   // [0]=min [1]=sec [2]=clr [3]=start
    int         reps;
    bit         done;
    int         e_min;
    int         e_sec;
    bit         e_run;
    bit         e_exp;
    int         e_loads;
  } vec_t;

  vec_t vecs[$];

  int total = 0, bad = 0;
  int load_cnt = 0, load_run = 0, load_max = 0, overlap = 0;
  int m_min, m_sec, m_state, m_loads;

  always @(negedge clk) begin
    if (load) begin
      load_cnt++;
      load_run++;
      if (load_run > load_max) load_max = load_run;
    end else begin
      load_run = 0;
    end
    if (running && expired) overlap++;
  end

  function automatic vec_t mk(logic [3:0] b, int reps, bit d, int em, int es,
                              bit er, bit ee, int el);
    vec_t v;
    v.btns = b; v.reps = reps; v.done = d;
    v.e_min = em; v.e_sec = es; v.e_run = er; v.e_exp = ee; v.e_loads = el;
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_output(input string tag, input int em, input int es,
                              input bit er, input bit ee, input int el);
    @(negedge clk);
    check({tag, ".min"},     int'(min),     em);
    check({tag, ".sec"},     int'(sec),     es);
    check({tag, ".running"}, int'(running), int'(er));
    check({tag, ".expired"}, int'(expired), int'(ee));
    check({tag, ".loads"},   load_cnt,      el);
  endtask

  task automatic apply_stimulus(input logic [3:0] mask);
    btn_min = mask[0]; btn_sec = mask[1]; btn_clr = mask[2]; btn_start = mask[3];
    tick(HOLD);
    btn_min = 1'b0; btn_sec = 1'b0; btn_clr = 1'b0; btn_start = 1'b0;
    tick(GAP);
  endtask

  task automatic pulse_done();
    timer_done = 1'b1;
    tick(2);
    timer_done = 1'b0;
    tick(3);
  endtask

  // Reference behaviour of one simultaneous set of presses.
  task automatic model_press(input logic [3:0] mask);
    case (m_state)
      S_EDIT: begin
        if (mask[2]) begin
          m_min = 0; m_sec = 0;
        end else if (mask[3] && (m_min + m_sec) > 0) begin
          m_loads++; m_state = S_RUN;
        end else begin
          if (mask[0]) m_min = (m_min + 1) % (MAXV + 1);
          if (mask[1]) m_sec = (m_sec + 1) % (MAXV + 1);
        end
      end
      S_RUN:  if (mask[2]) m_state = S_EDIT;
      default: begin
        if (mask[2]) begin m_min = 0; m_sec = 0; end
        m_state = S_EDIT;
      end
    endcase
  endtask

  initial begin
    int   found;
    logic [3:0] mask;

    // min, sec, clr, start encodings: 1, 2, 4, 8
    vecs.push_back(mk(4'h1,  3, 0,  3,  0, 0, 0, 0));
    vecs.push_back(mk(4'h2, 30, 0,  3, 30, 0, 0, 0));
    vecs.push_back(mk(4'h4,  1, 0,  0,  0, 0, 0, 0));
    vecs.push_back(mk(4'h8,  1, 0,  0,  0, 0, 0, 0));
    vecs.push_back(mk(4'h1, 59, 0, 59,  0, 0, 0, 0));
    vecs.push_back(mk(4'h2, 59, 0, 59, 59, 0, 0, 0));
    vecs.push_back(mk(4'h1,  1, 0,  0, 59, 0, 0, 0));
    vecs.push_back(mk(4'h2,  1, 0,  0,  0, 0, 0, 0));
    vecs.push_back(mk(4'h1,  1, 0,  1,  0, 0, 0, 0));
    vecs.push_back(mk(4'h2, 30, 0,  1, 30, 0, 0, 0));
    vecs.push_back(mk(4'h8,  1, 0,  1, 30, 1, 0, 1));
    vecs.push_back(mk(4'h1,  1, 0,  1, 30, 1, 0, 1));
    vecs.push_back(mk(4'h2,  1, 0,  1, 30, 1, 0, 1));
    vecs.push_back(mk(4'h0,  1, 1,  1, 30, 0, 1, 1));
    vecs.push_back(mk(4'h2,  1, 0,  1, 30, 0, 0, 1));
    vecs.push_back(mk(4'h8,  1, 0,  1, 30, 1, 0, 2));
    vecs.push_back(mk(4'h4,  1, 0,  1, 30, 0, 0, 2));
    vecs.push_back(mk(4'h8,  1, 0,  1, 30, 1, 0, 3));
    vecs.push_back(mk(4'h0,  1, 1,  1, 30, 0, 1, 3));
    vecs.push_back(mk(4'h4,  1, 0,  0,  0, 0, 0, 3));
    vecs.push_back(mk(4'h3,  2, 0,  2,  2, 0, 0, 3));
    vecs.push_back(mk(4'h5,  1, 0,  0,  0, 0, 0, 3));
    vecs.push_back(mk(4'h1,  1, 0,  1,  0, 0, 0, 3));
    vecs.push_back(mk(4'hA,  1, 0,  1,  0, 1, 0, 4));
    vecs.push_back(mk(4'h4,  1, 0,  1,  0, 0, 0, 4));
    vecs.push_back(mk(4'hC,  1, 0,  0,  0, 0, 0, 4));
    vecs.push_back(mk(4'h9,  1, 0,  1,  0, 0, 0, 4));
    vecs.push_back(mk(4'h8,  1, 0,  1,  0, 1, 0, 5));
    vecs.push_back(mk(4'h0,  1, 1,  1,  0, 0, 1, 5));
    vecs.push_back(mk(4'h8,  1, 0,  1,  0, 0, 0, 5));

    tick(3);
    check_output("reset_low", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick(3);
    check_output("reset", 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].done) pulse_done();
      else for (int k = 0; k < vecs[i].reps; k++) apply_stimulus(vecs[i].btns);
      check_output($sformatf("vec%0d", i), vecs[i].e_min, vecs[i].e_sec,
                   vecs[i].e_run, vecs[i].e_exp, vecs[i].e_loads);
    end

    // Bouncing sec button: only the final stable high counts.
    for (int i = 0; i < 10; i++) begin
      btn_sec = ~btn_sec;
      tick(2);
    end
    btn_sec = 1'b1;
    tick(HOLD);
    btn_sec = 1'b0;
    tick(GAP);
    check_output("glitch", 1, 1, 0, 0, 5);

    // Done flag present only in the first cycle after load must be ignored.
    btn_start = 1'b1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (load) begin found = 1; break; end
    end
    check("load_seen", found, 1);
    @(posedge clk);
    #1 timer_done = 1'b1;
    @(posedge clk);
    #1 timer_done = 1'b0;
    btn_start = 1'b0;
    tick(GAP);
    check_output("stale_done", 1, 1, 1, 0, 6);

    // Asynchronous reset in the middle of RUN.
    #3 rst_n = 1'b0;
    #1;
    check("rst_min", int'(min), 0);
    check("rst_sec", int'(sec), 0);
    check("rst_running", int'(running), 0);
    check("rst_expired", int'(expired), 0);
    check("rst_load", int'(load), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_output("after_rst", 0, 0, 0, 0, 6);

    m_min = 0; m_sec = 0; m_state = S_EDIT; m_loads = 6;

`ifdef TIMER_PRESET_AUTO_REPEAT_EN
    btn_sec = 1'b1;
    tick(DB + 2 + 49);
    btn_sec = 1'b0;
    tick(GAP);
    m_sec = 5;
    check_output("auto_repeat", m_min, m_sec, 0, 0, m_loads);
`endif

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 9) begin
        pulse_done();
        if (m_state == S_RUN) m_state = S_DONE;
      end else begin
        mask    = 4'h0;
        mask[0] = 1'($urandom_range(0, 1));
        mask[1] = 1'($urandom_range(0, 1));
        mask[2] = ($urandom_range(0, 7) == 0);
        mask[3] = ($urandom_range(0, 3) == 0);
        if (mask == 4'h0) mask[1] = 1'b1;
        apply_stimulus(mask);
        model_press(mask);
      end
      check_output($sformatf("rand%0d", i), m_min, m_sec,
                   m_state == S_RUN, m_state == S_DONE, m_loads);
    end

    check("load_width", load_max, 1);
    check("run_exp_overlap", overlap, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
